// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops finish on the accept edge, MUL iterates shift-add over DSIZE edges.
// Optional macro ALU_OVF_EN adds a registered signed/multiply overflow flag (ovf) and a 2*DSIZE accumulator.
module alu_mc #(
  parameter int DSIZE  = 16,
  parameter int OPSIZE = 4,
  parameter int CNTW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPSIZE-1:0] op,
  input  logic [DSIZE-1:0]  a,
  input  logic [DSIZE-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DSIZE-1:0]  out,
  output logic              zero,
  output logic              busy
`ifdef ALU_OVF_EN
  ,
  output logic              ovf
`endif
);

`ifdef ALU_OVF_EN
  localparam int ACCW = 2 * DSIZE;
`else
  localparam int ACCW = DSIZE;
`endif

  localparam logic [OPSIZE-1:0] OP_ADD  = OPSIZE'(0);
  localparam logic [OPSIZE-1:0] OP_SUB  = OPSIZE'(1);
  localparam logic [OPSIZE-1:0] OP_AND  = OPSIZE'(2);
  localparam logic [OPSIZE-1:0] OP_XOR  = OPSIZE'(3);
  localparam logic [OPSIZE-1:0] OP_COM  = OPSIZE'(4);
  localparam logic [OPSIZE-1:0] OP_MUL  = OPSIZE'(5);
  localparam logic [OPSIZE-1:0] OP_ADDI = OPSIZE'(6);
  localparam logic [OPSIZE-1:0] OP_LW   = OPSIZE'(7);
  localparam logic [OPSIZE-1:0] OP_SW   = OPSIZE'(8);

  if ((2 ** CNTW) <= DSIZE || DSIZE < 4) begin : g_param_check
    $error("alu_mc: need DSIZE >= 4 and 2**CNTW > DSIZE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DSIZE-1:0]  out_q, out_d;
  logic              zero_q, zero_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [ACCW-1:0]   mcand_q, mcand_d;
  logic [DSIZE-1:0]  mplier_q, mplier_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [ACCW-1:0]   acc_sum;
  logic [DSIZE-1:0]  alu_res;
  logic              accept;
  logic              is_mul;
  logic              last_iter;
`ifdef ALU_OVF_EN
  logic              ovf_q, ovf_d;
  logic              alu_ovf_bit;
`endif

  function automatic logic [DSIZE-1:0] alu_result(input logic [OPSIZE-1:0] f_op,
                                                  input logic [DSIZE-1:0]  f_a,
                                                  input logic [DSIZE-1:0]  f_b);
    logic [DSIZE-1:0] r;
    r = '0;
    case (f_op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: r = f_a + f_b;
      OP_SUB:                        r = f_a - f_b;
      OP_AND:                        r = f_a & f_b;
      OP_XOR:                        r = f_a ^ f_b;
      OP_COM:                        r = {{(DSIZE-1){1'b0}}, (f_a <= f_b)};
      default:                       r = '0;
    endcase
    return r;
  endfunction

`ifdef ALU_OVF_EN
  // Two's-complement overflow: operands agree in sign (after negating b for SUB) but the result does not.
  function automatic logic alu_overflow(input logic [OPSIZE-1:0] f_op,
                                        input logic [DSIZE-1:0]  f_a,
                                        input logic [DSIZE-1:0]  f_b);
    logic signed [DSIZE-1:0] sa;
    logic signed [DSIZE-1:0] sb;
    logic signed [DSIZE-1:0] sr;
    logic                    v;
    sa = f_a;
    sb = f_b;
    v  = 1'b0;
    case (f_op)
      OP_ADD, OP_ADDI: begin
        sr = sa + sb;
        v  = (sa[DSIZE-1] == sb[DSIZE-1]) && (sr[DSIZE-1] != sa[DSIZE-1]);
      end
      OP_SUB: begin
        sr = sa - sb;
        v  = (sa[DSIZE-1] != sb[DSIZE-1]) && (sr[DSIZE-1] != sa[DSIZE-1]);
      end
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  assign alu_ovf_bit = alu_overflow(op, a, b);
`endif

  assign alu_res   = alu_result(op, a, b);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MUL);
  assign last_iter = (cnt_q == CNTW'(DSIZE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = is_mul ? BUSY : HOLD;
      end
      BUSY: begin
        if (last_iter) state_d = HOLD;
      end
      HOLD: begin
        if (accept)         state_d = is_mul ? BUSY : HOLD;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    out_valid = (state_q == HOLD);
    busy      = (state_q == BUSY);
  end

  // Datapath: accept edge loads result or multiply operands; BUSY edges run one shift-add step each.
  always_comb begin
    out_d    = out_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
`ifdef ALU_OVF_EN
    ovf_d    = ovf_q;
`endif
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (accept) begin
      if (is_mul) begin
        mcand_d  = ACCW'(a);
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        out_d  = alu_res;
        zero_d = (alu_res == '0);
`ifdef ALU_OVF_EN
        ovf_d  = alu_ovf_bit;
`endif
      end
    end else if (state_q == BUSY) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNTW'(1);
      if (last_iter) begin
        out_d  = acc_sum[DSIZE-1:0];
        zero_d = (acc_sum[DSIZE-1:0] == '0);
`ifdef ALU_OVF_EN
        ovf_d  = |acc_sum[ACCW-1:DSIZE];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      zero_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
`ifdef ALU_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      out_q    <= out_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
`ifdef ALU_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign out  = out_q;
  assign zero = zero_q;
`ifdef ALU_OVF_EN
  assign ovf  = ovf_q;
`endif

  a_zero_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    zero_q == (out_q == '0));

  // A stalled result must not move until the consumer takes it.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == HOLD && !out_ready) |=> (state_q == HOLD && $stable(out_q) && $stable(zero_q)));

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at DSIZE=8: transaction-level reference model checked every cycle,
// plus hand-computed literal expectations for the documented scenarios.
module tb_alu_mc;
  localparam int DW = 8;
  localparam int OW = 4;
  localparam int CW = 4;
  localparam int MOD = 1 << DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [OW-1:0] op = '0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out;
  logic          zero;
  logic          busy;
`ifdef ALU_OVF_EN
  logic          ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_mc #(.DSIZE(DW), .OPSIZE(OW), .CNTW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .busy      (busy)
`ifdef ALU_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic from the operation definitions, using plain integers.
  function automatic int sx(input int v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  function automatic int ref_out(input int o, input int x, input int y);
    case (o)
      0, 6, 7, 8: return (x + y) % MOD;
      1:          return (x - y + MOD) % MOD;
      2:          return x & y;
      3:          return x ^ y;
      4:          return (x <= y) ? 1 : 0;
      default:    return 0;
    endcase
  endfunction

  function automatic bit ref_ovf(input int o, input int x, input int y);
    int s;
    case (o)
      0, 6: begin
        s = sx(x) + sx(y);
        return (s > MOD / 2 - 1) || (s < -MOD / 2);
      end
      1: begin
        s = sx(x) - sx(y);
        return (s > MOD / 2 - 1) || (s < -MOD / 2);
      end
      default: return 1'b0;
    endcase
  endfunction

  // Model: a result register with a valid bit, and a countdown for an in-flight multiply.
  bit m_valid = 1'b0;
  int m_out = 0;
  bit m_zero = 1'b1;
  bit m_ovf = 1'b0;
  int m_left = 0;
  int m_pend = 0;
  bit m_pend_ovf = 1'b0;
  bit m_rdy;
  bit exp_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_out   = 0;
      m_zero  = 1'b1;
      m_ovf   = 1'b0;
      m_left  = 0;
    end else begin
      m_rdy = (m_left == 0 && !m_valid) || (m_valid && out_ready);
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_out   = m_pend;
          m_zero  = (m_pend == 0);
          m_ovf   = m_pend_ovf;
          m_valid = 1'b1;
        end
      end else if (in_valid && m_rdy) begin
        if (int'(op) == 5) begin
          m_pend     = (int'(a) * int'(b)) % MOD;
          m_pend_ovf = ((int'(a) * int'(b)) / MOD) != 0;
          m_left     = DW;
          m_valid    = 1'b0;
        end else begin
          m_out   = ref_out(int'(op), int'(a), int'(b));
          m_zero  = (m_out == 0);
          m_ovf   = ref_ovf(int'(op), int'(a), int'(b));
          m_valid = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_rdy = (m_left == 0 && !m_valid) || (m_valid && out_ready);
    check("cyc_out_valid", out_valid, m_valid);
    check("cyc_busy", busy, m_left > 0);
    check("cyc_in_ready", in_ready, exp_rdy);
    check("cyc_out", out, m_out);
    check("cyc_zero", zero, m_zero);
`ifdef ALU_OVF_EN
    check("cyc_ovf", ovf, m_ovf);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input int o, input int x, input int y);
    in_valid = v;
    op = OW'(o);
    a  = DW'(x);
    b  = DW'(y);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 0, 0, 0);
    tick();
    tick();
    check("rst_out", out, 0);
    check("rst_zero", zero, 1);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);

    rst_n = 1'b1;
    drive(1'b1, 0, 200, 100);
    tick();
    check("add_out", out, 44);
    check("add_zero", zero, 0);
    check("add_valid", out_valid, 1);

    drive(1'b1, 1, 5, 5);
    tick();
    check("sub_out", out, 0);
    check("sub_zero", zero, 1);
    check("stream_ready", in_ready, 1);
    drive(1'b1, 4, 7, 7);
    tick();
    check("com_out", out, 1);
    check("com_zero", zero, 0);
    drive(1'b1, 15, 3, 9);
    tick();
    check("inv_out", out, 0);
    check("inv_zero", zero, 1);
    drive(1'b1, 3, 8'hF0, 8'h3C);
    tick();
    check("xor_out", out, 8'hCC);
    drive(1'b1, 6, 250, 10);
    tick();
    check("addi_out", out, 4);

    drive(1'b1, 5, 13, 11);
    tick();
    in_valid = 1'b0;
    check("mul_busy0", busy, 1);
    check("mul_ready0", in_ready, 0);
    check("mul_valid0", out_valid, 0);
    for (int i = 1; i < DW; i++) begin
      tick();
      check("mul_busy", busy, 1);
    end
    tick();
    check("mul_out", out, 143);
    check("mul_valid", out_valid, 1);
    check("mul_busy_end", busy, 0);

    drive(1'b1, 5, 255, 255);
    tick();
    in_valid = 1'b0;
    repeat (DW) tick();
    check("mul255_out", out, 1);
`ifdef ALU_OVF_EN
    check("mul255_ovf", ovf, 1);
`endif

    drive(1'b1, 5, 16, 16);
    tick();
    in_valid = 1'b0;
    repeat (DW) tick();
    check("mul256_out", out, 0);
    check("mul256_zero", zero, 1);

    drive(1'b1, 0, 3, 4);
    tick();
    check("bp_first", out, 7);
    out_ready = 1'b0;
    drive(1'b1, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", in_ready, 0);
      tick();
      check("bp_out", out, 7);
      check("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_next", out, 2);
    in_valid = 1'b0;

    drive(1'b1, 5, 13, 11);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out", out, 0);
    check("mid_rst_zero", zero, 1);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 0, 1, 2);
    tick();
    check("post_rst_out", out, 3);
    check("post_rst_valid", out_valid, 1);

    drive(1'b1, 0, 127, 1);
    tick();
    check("ovf_add_out", out, 128);
`ifdef ALU_OVF_EN
    check("ovf_add", ovf, 1);
`endif
    drive(1'b1, 1, 0, 1);
    tick();
    check("ovf_sub_out", out, 255);
`ifdef ALU_OVF_EN
    check("ovf_sub", ovf, 0);
`endif
    drive(1'b1, 2, 255, 255);
    tick();
    check("and_out", out, 255);
`ifdef ALU_OVF_EN
    check("ovf_and", ovf, 0);
`endif
    drive(1'b1, 1, 128, 1);
    tick();
    check("sub_wrap_out", out, 127);
`ifdef ALU_OVF_EN
    check("ovf_sub_neg", ovf, 1);
`endif
    in_valid = 1'b0;
    tick();
    check("idle_valid", out_valid, 0);
    check("idle_out_kept", out, 127);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
